// File: rtl/encaixotador_duzias.sv
// Crate/pallet packer for the wine conveyor: counts sealed bottles into crates,
// requests crate swaps and buffers one in-flight bottle. Pallet logic: ENCAIXOTADOR_PALETE_EN.
module encaixotador_duzias #(
    parameter int GARRAFAS_POR_CAIXA = 12,
    parameter int CAIXAS_POR_PALETE  = 4,
    parameter int TIMEOUT_TROCA      = 50
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       garrafa_in,
    input  logic       caixa_trocada,
    input  logic       palete_retirado,
    output logic [3:0] garrafas_caixa,
    output logic [2:0] caixas_palete,
    output logic       duzia_ok,
    output logic       pedido_troca,
    output logic       alarme_troca,
    output logic       bloqueio_esteira,
    output logic       erro_overflow,
    output logic [1:0] estado
);

    localparam logic [1:0] ENCHENDO     = 2'b00;
    localparam logic [1:0] TROCA        = 2'b01;
    localparam logic [1:0] PALETE_CHEIO = 2'b10;

    localparam int            CW     = $clog2(TIMEOUT_TROCA + 1);
    localparam logic [CW-1:0] T_MAX  = CW'(TIMEOUT_TROCA);
    localparam logic [3:0]    ULTIMA = 4'(GARRAFAS_POR_CAIXA - 1);

    if (GARRAFAS_POR_CAIXA < 2 || GARRAFAS_POR_CAIXA > 15) begin : g_chk_g
        $error("GARRAFAS_POR_CAIXA out of range 2..15");
    end
    if (CAIXAS_POR_PALETE < 1 || CAIXAS_POR_PALETE > 7) begin : g_chk_c
        $error("CAIXAS_POR_PALETE out of range 1..7");
    end
    if (TIMEOUT_TROCA < 1) begin : g_chk_t
        $error("TIMEOUT_TROCA must be at least 1");
    end

    logic          buffer;
    logic [CW-1:0] contador;
    logic [CW-1:0] contador_prox;
    logic [2:0]    caixas_prox;
    logic          saida;

    assign bloqueio_esteira = (estado != ENCHENDO);
    assign caixas_prox      = caixas_palete + 3'd1;
    assign contador_prox    = (contador == T_MAX) ? contador : contador + CW'(1);

    // PALETE_CHEIO can only be entered with the pallet feature built in,
    // so honouring palete_retirado there is harmless in the default build.
    always_comb begin
        saida = 1'b0;
        case (estado)
            ENCHENDO:     saida = 1'b0;
            TROCA:        saida = caixa_trocada;
            PALETE_CHEIO: saida = palete_retirado;
            default:      saida = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado         <= ENCHENDO;
            garrafas_caixa <= '0;
            caixas_palete  <= '0;
            duzia_ok       <= 1'b0;
            pedido_troca   <= 1'b0;
            alarme_troca   <= 1'b0;
            erro_overflow  <= 1'b0;
            buffer         <= 1'b0;
            contador       <= '0;
        end else begin
            duzia_ok <= 1'b0;
            if (estado == ENCHENDO) begin
                if (garrafa_in) begin
                    if (garrafas_caixa < ULTIMA) begin
                        garrafas_caixa <= garrafas_caixa + 4'd1;
                    end else begin
                        garrafas_caixa <= '0;
                        duzia_ok       <= 1'b1;
                        caixas_palete  <= caixas_prox;
                        pedido_troca   <= 1'b1;
                        contador       <= '0;
                        alarme_troca   <= 1'b0;
`ifdef ENCAIXOTADOR_PALETE_EN
                        estado <= (caixas_prox == 3'(CAIXAS_POR_PALETE)) ? PALETE_CHEIO : TROCA;
`else
                        estado <= TROCA;
`endif
                    end
                end
            end else if (saida) begin
                // A bottle arriving on the exit edge joins the buffered one in the new crate.
                estado         <= ENCHENDO;
                pedido_troca   <= 1'b0;
                garrafas_caixa <= {3'b000, buffer} + {3'b000, garrafa_in};
                buffer         <= 1'b0;
                contador       <= '0;
                alarme_troca   <= 1'b0;
                if (estado == PALETE_CHEIO) begin
                    caixas_palete <= '0;
                end
            end else begin
                contador     <= contador_prox;
                alarme_troca <= (contador_prox == T_MAX);
                if (garrafa_in) begin
                    if (buffer) begin
                        erro_overflow <= 1'b1;
                    end else begin
                        buffer <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_encaixotador_duzias.sv
// Directed bench for encaixotador_duzias with default parameters (G=12, C=4, T=50).
module tb_encaixotador_duzias;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       garrafa_in = 1'b0;
    logic       caixa_trocada = 1'b0;
    logic       palete_retirado = 1'b0;
    logic [3:0] garrafas_caixa;
    logic [2:0] caixas_palete;
    logic       duzia_ok;
    logic       pedido_troca;
    logic       alarme_troca;
    logic       bloqueio_esteira;
    logic       erro_overflow;
    logic [1:0] estado;

    int errors = 0;
    int checks = 0;

    encaixotador_duzias #(
        .GARRAFAS_POR_CAIXA(12),
        .CAIXAS_POR_PALETE (4),
        .TIMEOUT_TROCA     (50)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .garrafa_in      (garrafa_in),
        .caixa_trocada   (caixa_trocada),
        .palete_retirado (palete_retirado),
        .garrafas_caixa  (garrafas_caixa),
        .caixas_palete   (caixas_palete),
        .duzia_ok        (duzia_ok),
        .pedido_troca    (pedido_troca),
        .alarme_troca    (alarme_troca),
        .bloqueio_esteira(bloqueio_esteira),
        .erro_overflow   (erro_overflow),
        .estado          (estado)
    );

    always #5 clk = ~clk;

    // Returns 1 time unit after the rising edge, so outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bottles(input int n);
        for (int i = 0; i < n; i++) begin
            garrafa_in = 1'b1;
            tick();
            garrafa_in = 1'b0;
        end
    endtask

    task automatic swap_pulse();
        caixa_trocada = 1'b1;
        tick();
        caixa_trocada = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({garrafas_caixa, caixas_palete, duzia_ok, pedido_troca, alarme_troca,
             bloqueio_esteira, erro_overflow, estado} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {garrafas_caixa, caixas_palete, duzia_ok, pedido_troca, alarme_troca,
                      bloqueio_esteira, erro_overflow, estado});
        end
    endtask

    task automatic test_fill_crate();
        do_reset();
        bottles(11);
        checks++;
        if (garrafas_caixa !== 4'd11 || duzia_ok !== 1'b0 || estado !== 2'b00) begin
            errors++;
            $display("FAIL fill_11: got count=%0d duzia=%0d estado=%0d expected 11/0/0",
                     garrafas_caixa, duzia_ok, estado);
        end
        bottles(1);
        checks++;
        if (garrafas_caixa !== 4'd0 || duzia_ok !== 1'b1 || caixas_palete !== 3'd1) begin
            errors++;
            $display("FAIL fill_12_counts: got count=%0d duzia=%0d caixas=%0d expected 0/1/1",
                     garrafas_caixa, duzia_ok, caixas_palete);
        end
        checks++;
        if (estado !== 2'b01 || pedido_troca !== 1'b1 || bloqueio_esteira !== 1'b1) begin
            errors++;
            $display("FAIL fill_12_swap: got estado=%0d pedido=%0d bloqueio=%0d expected 1/1/1",
                     estado, pedido_troca, bloqueio_esteira);
        end
        tick();
        checks++;
        if (duzia_ok !== 1'b0) begin
            errors++;
            $display("FAIL duzia_one_cycle: got %0d expected 0", duzia_ok);
        end
        swap_pulse();
        checks++;
        if (estado !== 2'b00 || pedido_troca !== 1'b0 || bloqueio_esteira !== 1'b0 ||
            garrafas_caixa !== 4'd0) begin
            errors++;
            $display("FAIL swap_exit: got estado=%0d pedido=%0d bloqueio=%0d count=%0d expected 0/0/0/0",
                     estado, pedido_troca, bloqueio_esteira, garrafas_caixa);
        end
        // Swap pulses in ENCHENDO are ignored
        bottles(3);
        swap_pulse();
        checks++;
        if (estado !== 2'b00 || garrafas_caixa !== 4'd3) begin
            errors++;
            $display("FAIL swap_in_enchendo: got estado=%0d count=%0d expected 0/3",
                     estado, garrafas_caixa);
        end
    endtask

    task automatic test_buffer_overflow();
        do_reset();
        bottles(12);
        bottles(1);
        swap_pulse();
        checks++;
        if (garrafas_caixa !== 4'd1 || erro_overflow !== 1'b0) begin
            errors++;
            $display("FAIL buffer_one: got count=%0d overflow=%0d expected 1/0",
                     garrafas_caixa, erro_overflow);
        end
        bottles(11);
        checks++;
        if (estado !== 2'b01 || caixas_palete !== 3'd2) begin
            errors++;
            $display("FAIL second_crate: got estado=%0d caixas=%0d expected 1/2", estado, caixas_palete);
        end
        bottles(2);
        checks++;
        if (erro_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got %0d expected 1", erro_overflow);
        end
        swap_pulse();
        checks++;
        if (garrafas_caixa !== 4'd1 || erro_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_exit: got count=%0d overflow=%0d expected 1/1",
                     garrafas_caixa, erro_overflow);
        end
        bottles(4);
        checks++;
        if (erro_overflow !== 1'b1 || garrafas_caixa !== 4'd5) begin
            errors++;
            $display("FAIL overflow_sticky: got overflow=%0d count=%0d expected 1/5",
                     erro_overflow, garrafas_caixa);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bottles(12);
        bottles(1);
        garrafa_in    = 1'b1;
        caixa_trocada = 1'b1;
        tick();
        garrafa_in    = 1'b0;
        caixa_trocada = 1'b0;
        checks++;
        if (garrafas_caixa !== 4'd2 || erro_overflow !== 1'b0 || estado !== 2'b00) begin
            errors++;
            $display("FAIL simultaneous: got count=%0d overflow=%0d estado=%0d expected 2/0/0",
                     garrafas_caixa, erro_overflow, estado);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bottles(12);
        for (int i = 0; i < 49; i++) tick();
        checks++;
        if (alarme_troca !== 1'b0) begin
            errors++;
            $display("FAIL alarm_early: got %0d expected 0 after 49 cycles", alarme_troca);
        end
        tick();
        checks++;
        if (alarme_troca !== 1'b1) begin
            errors++;
            $display("FAIL alarm_at_50: got %0d expected 1", alarme_troca);
        end
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (alarme_troca !== 1'b1) begin
            errors++;
            $display("FAIL alarm_saturate: got %0d expected 1", alarme_troca);
        end
        swap_pulse();
        checks++;
        if (alarme_troca !== 1'b0 || estado !== 2'b00) begin
            errors++;
            $display("FAIL alarm_clear: got alarm=%0d estado=%0d expected 0/0", alarme_troca, estado);
        end
        // A fresh swap restarts the count from zero
        bottles(12);
        for (int i = 0; i < 49; i++) tick();
        checks++;
        if (alarme_troca !== 1'b0) begin
            errors++;
            $display("FAIL alarm_restart: got %0d expected 0", alarme_troca);
        end
        swap_pulse();
    endtask

    task automatic test_pallet();
        do_reset();
        for (int c = 0; c < 3; c++) begin
            bottles(12);
            swap_pulse();
        end
        bottles(12);
`ifdef ENCAIXOTADOR_PALETE_EN
        checks++;
        if (caixas_palete !== 3'd4 || estado !== 2'b10 || pedido_troca !== 1'b1) begin
            errors++;
            $display("FAIL pallet_full: got caixas=%0d estado=%0d pedido=%0d expected 4/2/1",
                     caixas_palete, estado, pedido_troca);
        end
        swap_pulse();
        checks++;
        if (estado !== 2'b10) begin
            errors++;
            $display("FAIL pallet_ignores_swap: got estado=%0d expected 2", estado);
        end
        palete_retirado = 1'b1;
        tick();
        palete_retirado = 1'b0;
        checks++;
        if (caixas_palete !== 3'd0 || estado !== 2'b00) begin
            errors++;
            $display("FAIL pallet_removed: got caixas=%0d estado=%0d expected 0/0", caixas_palete, estado);
        end
`else
        checks++;
        if (caixas_palete !== 3'd4 || estado !== 2'b01) begin
            errors++;
            $display("FAIL crate4_troca: got caixas=%0d estado=%0d expected 4/1", caixas_palete, estado);
        end
        palete_retirado = 1'b1;
        tick();
        palete_retirado = 1'b0;
        checks++;
        if (estado !== 2'b01 || caixas_palete !== 3'd4) begin
            errors++;
            $display("FAIL pallet_pulse_ignored: got estado=%0d caixas=%0d expected 1/4", estado, caixas_palete);
        end
        swap_pulse();
        for (int c = 0; c < 3; c++) begin
            bottles(12);
            swap_pulse();
        end
        checks++;
        if (caixas_palete !== 3'd7) begin
            errors++;
            $display("FAIL crate7: got caixas=%0d expected 7", caixas_palete);
        end
        bottles(12);
        checks++;
        if (caixas_palete !== 3'd0 || estado !== 2'b01) begin
            errors++;
            $display("FAIL crate_wrap: got caixas=%0d estado=%0d expected 0/1", caixas_palete, estado);
        end
        swap_pulse();
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        bottles(12);
        bottles(2);
        #1;
        reset = 1'b1;
        #2;
        checks++;
        if ({garrafas_caixa, caixas_palete, duzia_ok, pedido_troca, alarme_troca,
             bloqueio_esteira, erro_overflow, estado} !== 14'd0) begin
            errors++;
            $display("FAIL reset_async: got %b expected all zero",
                     {garrafas_caixa, caixas_palete, duzia_ok, pedido_troca, alarme_troca,
                      bloqueio_esteira, erro_overflow, estado});
        end
        reset = 1'b0;
        bottles(7);
        #1;
        reset = 1'b1;
        #2;
        checks++;
        if (garrafas_caixa !== 4'd0 || estado !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid_crate: got count=%0d estado=%0d expected 0/0", garrafas_caixa, estado);
        end
        reset = 1'b0;
        bottles(1);
        checks++;
        if (garrafas_caixa !== 4'd1 || caixas_palete !== 3'd0) begin
            errors++;
            $display("FAIL after_reset: got count=%0d caixas=%0d expected 1/0", garrafas_caixa, caixas_palete);
        end
    endtask

    initial begin
        test_reset();
        test_fill_crate();
        test_buffer_overflow();
        test_simultaneous();
        test_timeout();
        test_pallet();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
